// File: rtl/sysid_checker.sv
// Boot-time system-ID checker: reads the ID and timestamp words from the sysid
// slave after reset, compares them with build-time constants and publishes status.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h550F_7EC9,
    parameter bit          CHECK_TS       = 1'b1,
    parameter int          START_DELAY    = 16,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        restart,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        done,
    output logic        match,
    output logic        timeout_err,
    output logic [2:0]  fsm_state
);

    // Avalon-MM read handshake: a read is accepted on a rising edge where
    // avm_read=1 and avm_waitrequest=0; address and read are held stable
    // while waitrequest=1, and readdata is captured only on acceptance.

    typedef enum logic [2:0] {
        S_WAIT  = 3'd0,
        S_RD_ID = 3'd1,
        S_RD_TS = 3'd2,
        S_CMP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [7:0]  DELAY_LAST = 8'(START_DELAY - 1);
    localparam logic [15:0] TO_LAST    = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nxt;
    logic [7:0]  delay_cnt, delay_cnt_nxt;
    logic [15:0] to_cnt, to_cnt_nxt;
    logic        read_nxt, address_nxt;
    logic [31:0] id_nxt, ts_nxt;
    logic        done_nxt, match_nxt, timeout_nxt;
    logic        stall_limit;
    logic [15:0] to_cnt_inc;

    assign fsm_state   = state;
    assign stall_limit = avm_waitrequest && (to_cnt == TO_LAST);
    assign to_cnt_inc  = (to_cnt == 16'hFFFF) ? to_cnt : to_cnt + 16'd1;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= S_WAIT;
            delay_cnt   <= 8'd0;
            to_cnt      <= 16'd0;
            avm_read    <= 1'b0;
            avm_address <= 1'b0;
            id_value    <= 32'd0;
            ts_value    <= 32'd0;
            done        <= 1'b0;
            match       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            delay_cnt   <= delay_cnt_nxt;
            to_cnt      <= to_cnt_nxt;
            avm_read    <= read_nxt;
            avm_address <= address_nxt;
            id_value    <= id_nxt;
            ts_value    <= ts_nxt;
            done        <= done_nxt;
            match       <= match_nxt;
            timeout_err <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT:  if (delay_cnt == DELAY_LAST) state_nxt = S_RD_ID;
            S_RD_ID: begin
                if (!avm_waitrequest)  state_nxt = S_RD_TS;
                else if (stall_limit)  state_nxt = S_DONE;
            end
            S_RD_TS: begin
                if (!avm_waitrequest)  state_nxt = S_CMP;
                else if (stall_limit)  state_nxt = S_DONE;
            end
            S_CMP:   state_nxt = S_DONE;
            S_DONE:  if (restart) state_nxt = S_WAIT;
            default: state_nxt = S_WAIT;
        endcase
    end

    // Output process computes the next value of every registered output.
    always_comb begin
        delay_cnt_nxt = delay_cnt;
        to_cnt_nxt    = to_cnt;
        read_nxt      = avm_read;
        address_nxt   = avm_address;
        id_nxt        = id_value;
        ts_nxt        = ts_value;
        done_nxt      = done;
        match_nxt     = match;
        timeout_nxt   = timeout_err;
        case (state)
            S_WAIT: begin
                if (delay_cnt == DELAY_LAST) begin
                    read_nxt    = 1'b1;
                    address_nxt = 1'b0;
                    to_cnt_nxt  = 16'd0;
                end else begin
                    delay_cnt_nxt = delay_cnt + 8'd1;
                end
            end
            S_RD_ID, S_RD_TS: begin
                if (!avm_waitrequest) begin
                    to_cnt_nxt = 16'd0;
                    if (state == S_RD_ID) begin
                        id_nxt      = avm_readdata;
                        address_nxt = 1'b1;
                    end else begin
                        ts_nxt      = avm_readdata;
                        read_nxt    = 1'b0;
                        address_nxt = 1'b0;
                    end
                end else if (stall_limit) begin
                    read_nxt    = 1'b0;
                    address_nxt = 1'b0;
                    timeout_nxt = 1'b1;
                    match_nxt   = 1'b0;
                    done_nxt    = 1'b1;
                end else begin
                    to_cnt_nxt = to_cnt_inc;
                end
            end
            S_CMP: begin
                match_nxt = (id_value == EXPECTED_ID) &&
                            (!CHECK_TS || (ts_value == EXPECTED_TS));
                done_nxt  = 1'b1;
            end
            S_DONE: begin
                if (restart) begin
                    done_nxt      = 1'b0;
                    match_nxt     = 1'b0;
                    timeout_nxt   = 1'b0;
                    delay_cnt_nxt = 8'd0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sysid_checker.sv
// Self-checking bench for sysid_checker: table-driven and random read sequences
// against an event-timing model, plus reset-mid-read and restart corner cases.
module tb_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'h0000_0000;
    localparam logic [31:0] EXP_TS = 32'h550F_7EC9;
    localparam int          SD     = 16;
    localparam int          TO     = 255;

    logic        clock;
    logic        reset_n;
    logic        restart;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_address, avm_read, done, match, timeout_err;
    logic [31:0] id_value, ts_value;
    logic [2:0]  fsm_state;
    logic        d2_address, d2_read, d2_done, d2_match, d2_timeout_err;
    logic [31:0] d2_id_value, d2_ts_value;
    logic [2:0]  d2_fsm_state;

    int total = 0;
    int bad   = 0;
    logic [31:0] prev_id = 32'd0;
    logic [31:0] prev_ts = 32'd0;

    typedef struct {
        logic [31:0] id_w;
        logic [31:0] ts_w;
        int          w_id;
        int          w_ts;
        int          rst_cyc;
        logic        exp_m;
        logic        exp_m2;
        logic        exp_to;
    } vec_t;

    vec_t vecs[12];

    sysid_checker #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .CHECK_TS(1'b1),
        .START_DELAY(SD), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset_n(reset_n), .restart(restart),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .id_value(id_value), .ts_value(ts_value), .done(done), .match(match),
        .timeout_err(timeout_err), .fsm_state(fsm_state)
    );

    sysid_checker #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .CHECK_TS(1'b0),
        .START_DELAY(SD), .TIMEOUT_CYCLES(TO)
    ) dut_nots (
        .clock(clock), .reset_n(reset_n), .restart(restart),
        .avm_address(d2_address), .avm_read(d2_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .id_value(d2_id_value), .ts_value(d2_ts_value), .done(d2_done), .match(d2_match),
        .timeout_err(d2_timeout_err), .fsm_state(d2_fsm_state)
    );

    // clock / watchdog
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(posedge clock); #1;
        restart = 1'b0;
        check("restart_clears_done", {31'd0, done}, 32'd0);
        check("restart_clears_to", {31'd0, timeout_err}, 32'd0);
    endtask

    // Drives one full check sequence; cycle 1 is the first edge after the
    // reset-release or restart edge. Expected timing comes from the stall counts.
    task automatic run_seq(input vec_t v, input string tag);
        int c, rise_cyc, done_cyc, st_id, st_ts, exp_done;
        logic stable_ok, stalled, acc_id, prev_addr;
        logic [31:0] exp_id, exp_ts;
        if (v.w_id >= TO) begin
            exp_done = SD + TO;
            exp_id = prev_id; exp_ts = prev_ts;
        end else if (v.w_ts >= TO) begin
            exp_done = SD + v.w_id + 1 + TO;
            exp_id = v.id_w; exp_ts = prev_ts;
        end else begin
            exp_done = SD + v.w_id + v.w_ts + 3;
            exp_id = v.id_w; exp_ts = v.ts_w;
        end
        c = 0; rise_cyc = -1; done_cyc = -1; st_id = 0; st_ts = 0; stable_ok = 1'b1;
        while (done_cyc < 0 && c < 2000) begin
            restart = (c + 1 == v.rst_cyc);
            if (avm_read && !avm_address) begin
                avm_waitrequest = (st_id < v.w_id);
                if (avm_waitrequest) st_id++;
            end else if (avm_read) begin
                avm_waitrequest = (st_ts < v.w_ts);
                if (avm_waitrequest) st_ts++;
            end else begin
                avm_waitrequest = 1'($urandom_range(0, 1));
            end
            if (avm_read && !avm_waitrequest)
                avm_readdata = avm_address ? v.ts_w : v.id_w;
            else
                avm_readdata = $urandom();
            stalled   = avm_read && avm_waitrequest;
            acc_id    = avm_read && !avm_address && !avm_waitrequest;
            prev_addr = avm_address;
            @(posedge clock); #1;
            c++;
            if (avm_read && rise_cyc < 0) begin
                rise_cyc = c;
                if (avm_address) stable_ok = 1'b0;
            end
            if (stalled && !done && !(avm_read && avm_address == prev_addr)) stable_ok = 1'b0;
            if (acc_id && !(avm_read && avm_address)) stable_ok = 1'b0;
            if (done) done_cyc = c;
        end
        restart = 1'b0;
        avm_waitrequest = 1'b0;
        check({tag, "_rise"}, rise_cyc, SD);
        check({tag, "_done_cyc"}, done_cyc, exp_done);
        check({tag, "_handshake"}, {31'd0, stable_ok}, 32'd1);
        check({tag, "_match"}, {31'd0, match}, {31'd0, v.exp_m});
        check({tag, "_match_nots"}, {31'd0, d2_match}, {31'd0, v.exp_m2});
        check({tag, "_timeout"}, {31'd0, timeout_err}, {31'd0, v.exp_to});
        check({tag, "_read_low"}, {31'd0, avm_read}, 32'd0);
        check({tag, "_id"}, id_value, exp_id);
        check({tag, "_ts"}, ts_value, exp_ts);
        prev_id = exp_id;
        prev_ts = exp_ts;
    endtask

    initial begin
        vec_t rv;
        logic reached;
        restart = 1'b0;
        avm_waitrequest = 1'b0;
        avm_readdata = 32'd0;

        //           id_w          ts_w          w_id  w_ts rst  m     m2    to
        vecs[0]  = '{32'h0,        EXP_TS,       0,    0,   -1,  1'b1, 1'b1, 1'b0};
        vecs[1]  = '{32'h0,        32'h550F7ECA, 0,    0,   -1,  1'b0, 1'b1, 1'b0};
        vecs[2]  = '{32'h0,        EXP_TS,       5,    5,   -1,  1'b1, 1'b1, 1'b0};
        vecs[3]  = '{32'h0,        EXP_TS,       1000, 0,   -1,  1'b0, 1'b0, 1'b1};
        vecs[4]  = '{32'h0,        EXP_TS,       254,  0,   -1,  1'b1, 1'b1, 1'b0};
        vecs[5]  = '{32'h0,        EXP_TS,       255,  0,   -1,  1'b0, 1'b0, 1'b1};
        vecs[6]  = '{32'h1,        EXP_TS,       0,    0,   5,   1'b0, 1'b0, 1'b0};
        vecs[7]  = '{32'h0,        EXP_TS,       5,    0,   18,  1'b1, 1'b1, 1'b0};
        vecs[8]  = '{32'h0,        EXP_TS,       0,    0,   19,  1'b1, 1'b1, 1'b0};
        vecs[9]  = '{32'hDEADBEEF, EXP_TS,       2,    255, -1,  1'b0, 1'b0, 1'b1};
        vecs[10] = '{32'h0,        32'h0,        3,    254, -1,  1'b0, 1'b1, 1'b0};
        vecs[11] = '{32'h0,        EXP_TS,       1,    1,   -1,  1'b1, 1'b1, 1'b0};

        // reset block
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_read", {31'd0, avm_read}, 32'd0);
        check("rst_addr", {31'd0, avm_address}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_match", {31'd0, match}, 32'd0);
        check("rst_timeout", {31'd0, timeout_err}, 32'd0);
        check("rst_id", id_value, 32'd0);
        check("rst_ts", ts_value, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            if (i != 0) do_restart();
            run_seq(vecs[i], $sformatf("vec%0d", i));
        end

        // random sequences checked against the rule-level model
        for (int i = 0; i < 10; i++) begin
            rv.id_w = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom();
            case ($urandom_range(0, 2))
                0:       rv.ts_w = EXP_TS;
                1:       rv.ts_w = EXP_TS ^ (32'd1 << $urandom_range(0, 31));
                default: rv.ts_w = $urandom();
            endcase
            rv.w_id = ($urandom_range(0, 7) == 0) ? $urandom_range(250, 258) : $urandom_range(0, 6);
            rv.w_ts = ($urandom_range(0, 7) == 0) ? $urandom_range(250, 258) : $urandom_range(0, 6);
            rv.rst_cyc = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 30) : -1;
            rv.exp_to = (rv.w_id >= TO) || (rv.w_ts >= TO);
            rv.exp_m  = !rv.exp_to && (rv.id_w == EXP_ID) && (rv.ts_w == EXP_TS);
            rv.exp_m2 = !rv.exp_to && (rv.id_w == EXP_ID);
            do_restart();
            run_seq(rv, $sformatf("rnd%0d", i));
        end

        // reset asserted for one cycle while the timestamp read is stalled
        do_restart();
        reached = 1'b0;
        for (int c = 0; c < 100 && !reached; c++) begin
            avm_waitrequest = avm_read && avm_address;
            avm_readdata = 32'h1234_5678;
            @(posedge clock); #1;
            reached = avm_read && avm_address;
        end
        check("midrd_reached_rd_ts", {31'd0, reached}, 32'd1);
        avm_waitrequest = 1'b1;
        @(posedge clock); #1;
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        avm_waitrequest = 1'b0;
        check("midrd_read", {31'd0, avm_read}, 32'd0);
        check("midrd_addr", {31'd0, avm_address}, 32'd0);
        check("midrd_done", {31'd0, done}, 32'd0);
        check("midrd_match", {31'd0, match}, 32'd0);
        check("midrd_timeout", {31'd0, timeout_err}, 32'd0);
        check("midrd_id", id_value, 32'd0);
        check("midrd_ts", ts_value, 32'd0);
        prev_id = 32'd0;
        prev_ts = 32'd0;
        run_seq(vecs[0], "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sysid_checker.md
Name: sysid_checker

Overview:
- Avalon-MM read master that sits directly downstream of the system-ID slave and consumes its 32-bit readdata.
- After reset it reads the ID word (address 0), then the timestamp word (address 1), and compares both against build-time expected values.
- It publishes done / match / timeout status for boot-gating logic and the debug LEDs.
- Runs on the same clock and reset as the sysid slave; the interconnect path may insert waitrequest.

Parameters:
- EXPECTED_ID, 32'h0000_0000, value expected at address 0.
- EXPECTED_TS, 32'h550F_7EC9 (1427078857), value expected at address 1.
- CHECK_TS, 1, 1 = timestamp must also match; 0 = timestamp captured but ignored in the match decision.
- START_DELAY, 16, idle cycles after reset release before the first read (1..255).
- TIMEOUT_CYCLES, 255, maximum cycles a single read may be held off by waitrequest (1..65535).

Ports:
- clock  in  1  system clock; sole clock domain.
- reset_n  in  1  synchronous, active-low reset; sampled on the rising edge of clock.
- restart  in  1  single-cycle pulse; re-runs the check. Honoured only in the DONE state.
- avm_address  out  1  0 = ID word, 1 = timestamp word.
- avm_read  out  1  Avalon read strobe.
- avm_waitrequest  in  1  slave/fabric stall.
- avm_readdata  in  32  read data; valid in the cycle avm_read=1 and avm_waitrequest=0.
- id_value  out  32  captured ID word.
- ts_value  out  32  captured timestamp word.
- done  out  1  check finished, including on timeout.
- match  out  1  check passed; meaningful only while done=1.
- timeout_err  out  1  a read exceeded TIMEOUT_CYCLES.

Behaviour:
- Reset (reset_n=0 at an edge) values:
  - state=WAIT.
  - avm_read=0, avm_address=0.
  - id_value=0, ts_value=0.
  - done=0, match=0, timeout_err=0.
  - delay and timeout counters cleared.
- Reset mid-read: the same reset values apply. avm_read drops at that edge; no partial capture survives.
- All outputs are registered. No combinational path from any input to any output.
- FSM states: WAIT, RD_ID, RD_TS, CMP, DONE.
- WAIT:
  - The delay counter increments each cycle.
  - When it reaches START_DELAY-1, go to RD_ID with avm_read=1 and avm_address=0 registered on that edge.
  - Result: the first read is visible START_DELAY cycles after the first edge with reset_n=1.
- RD_ID:
  - Hold avm_read=1 and avm_address=0 stable while avm_waitrequest=1.
  - On an edge with avm_waitrequest=0: capture avm_readdata into id_value, set avm_address=1, keep avm_read=1, enter RD_TS.
  - This makes the reads back-to-back, with no idle cycle between them.
- RD_TS:
  - Same handshake as RD_ID.
  - On acceptance: capture into ts_value, set avm_read=0 and avm_address=0, enter CMP.
- Timeout:
  - The timeout counter clears on entry to each read state and increments each cycle avm_waitrequest=1.
  - If it reaches TIMEOUT_CYCLES while waitrequest is still 1: avm_read=0, timeout_err=1, match=0, done=1, enter DONE.
  - The word not yet read keeps its previous value.
- CMP (one cycle):
  - match = (id_value==EXPECTED_ID) && (!CHECK_TS || ts_value==EXPECTED_TS).
  - done=1, enter DONE.
  - With zero waitrequest, done rises 3 cycles after avm_read first rises.
- DONE:
  - done, match, timeout_err, id_value and ts_value hold.
  - restart=1 clears done, match and timeout_err and the delay counter, and enters WAIT.
  - id_value and ts_value hold until they are overwritten by the next capture.
  - restart in any other state is ignored.
- Simultaneous events:
  - reset_n=0 overrides restart and all handshakes.
  - A read accepted in the same cycle the timeout counter reaches its limit counts as accepted, not as a timeout.
- Widths: avm_readdata is compared as full 32-bit unsigned values. The delay counter is 8 bits; the timeout counter is 16 bits, saturating.

Test Plan:
1. Reset, then model a zero-wait slave returning 0 for address 0 and 1427078857 for address 1.
   -> avm_read rises on cycle 16.
   -> Reads are addr 0, then addr 1, on consecutive cycles.
   -> done=1 and match=1 on cycle 19.
   -> id_value=0, ts_value=32'h550F_7EC9.
2. Slave returns timestamp 32'h550F_7ECA with CHECK_TS=1.
   -> done=1, match=0, timeout_err=0.
   -> Repeat with CHECK_TS=0 -> match=1.
3. waitrequest held for 5 cycles on each read.
   -> address and read stay stable throughout.
   -> done rises 13 cycles after the first read assertion.
   -> match=1.
4. waitrequest stuck at 1 with TIMEOUT_CYCLES=255.
   -> avm_read drops after 255 stalled cycles.
   -> timeout_err=1, done=1, match=0, id_value=0.
5. Drive reset_n=0 for 1 cycle while in RD_TS.
   -> avm_read=0 and all status outputs are 0 on the next cycle.
   -> The full sequence restarts after 16 cycles.
6. Pulse restart in DONE, then pulse restart during RD_ID.
   -> The first pulse triggers a second full read pair with done low during it.
   -> The second pulse has no effect on the sequence.
